// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops, iterative shift-add MUL
// and restoring DIVU/REMU. Results and flags are registered and held until the next done.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       AluControl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zeroflag,
  output logic             signflag,
  output logic             carryflag,
  output logic             overflowflag,
  output logic             divzero,
  output logic             illegal_op
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_reg, state_next;

  logic [3:0]         op_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0] acc_reg, mcand_reg;
  logic [SHW-1:0]     cnt_reg;
  logic [WIDTH-1:0]   out_reg;
  logic zero_reg, sign_reg, carry_reg, ovf_reg, divzero_reg, illegal_reg;

  logic               accept, capture, last_step;
  logic [WIDTH:0]     add_full, sub_full, sll_full, srl_full, sra_full;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_carry, sc_ovf, sc_divzero, sc_illegal, sc_multi;
  logic [2*WIDTH-1:0] mul_acc_step;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   div_rem_step, div_quo_step;
  logic [WIDTH-1:0]   cap_result;
  logic               cap_carry, cap_ovf;

  assign accept    = start && (state_reg == IDLE);
  assign last_step = (cnt_reg == LAST_STEP);

  // Single-cycle results, evaluated directly from the ports at acceptance.
  always_comb begin
    add_full   = {1'b0, in_a} + {1'b0, in_b};
    sub_full   = {1'b0, in_a} - {1'b0, in_b};
    shamt      = in_b[SHW-1:0];
    sll_full   = {1'b0, in_a} << shamt;
    srl_full   = {in_a, 1'b0} >> shamt;
    sra_full   = $signed({in_a, 1'b0}) >>> shamt;
    sc_result  = '0;
    sc_carry   = 1'b0;
    sc_ovf     = 1'b0;
    sc_divzero = 1'b0;
    sc_illegal = 1'b0;
    sc_multi   = 1'b0;
    case (AluControl)
      OP_ADD: begin
        sc_result = add_full[WIDTH-1:0];
        sc_carry  = add_full[WIDTH];
        sc_ovf    = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_full[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = sub_full[WIDTH-1:0];
        sc_carry  = sub_full[WIDTH];
        sc_ovf    = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_full[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND: sc_result = in_a & in_b;
      OP_OR:  sc_result = in_a | in_b;
      OP_XOR: sc_result = in_a ^ in_b;
      OP_SLL: begin
        sc_result = sll_full[WIDTH-1:0];
        sc_carry  = sll_full[WIDTH];
      end
      OP_SRL: begin
        sc_result = srl_full[WIDTH:1];
        sc_carry  = srl_full[0];
      end
      OP_SRA: begin
        sc_result = sra_full[WIDTH:1];
        sc_carry  = sra_full[0];
      end
      OP_MUL: sc_multi = 1'b1;
      OP_DIVU: begin
        if (in_b == '0) begin
          sc_result  = '1;
          sc_divzero = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
      OP_REMU: begin
        if (in_b == '0) begin
          sc_result  = in_a;
          sc_divzero = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      default: sc_illegal = 1'b1;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide; the final
  // result is taken from the step values of the last iteration.
  always_comb begin
    mul_acc_step = acc_reg + (a_reg[0] ? mcand_reg : '0);
    div_trial    = {acc_reg[WIDTH-1:0], a_reg[WIDTH-1]} - {1'b0, b_reg};
    div_rem_step = div_trial[WIDTH] ? {acc_reg[WIDTH-2:0], a_reg[WIDTH-1]} : div_trial[WIDTH-1:0];
    div_quo_step = {a_reg[WIDTH-2:0], ~div_trial[WIDTH]};
    capture      = (accept && !sc_multi) || ((state_reg == RUN) && last_step);
    cap_result   = sc_result;
    cap_carry    = sc_carry;
    cap_ovf      = sc_ovf;
    if (state_reg == RUN) begin
      cap_carry = 1'b0;
      cap_ovf   = 1'b0;
      case (op_reg)
        OP_MUL: begin
          cap_result = mul_acc_step[WIDTH-1:0];
          cap_carry  = |mul_acc_step[2*WIDTH-1:WIDTH];
          cap_ovf    = |mul_acc_step[2*WIDTH-1:WIDTH];
        end
        OP_REMU: cap_result = div_rem_step;
        default: cap_result = div_quo_step;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = sc_multi ? RUN : DONE;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      cnt_reg     <= '0;
      out_reg     <= '0;
      zero_reg    <= 1'b0;
      sign_reg    <= 1'b0;
      carry_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
      divzero_reg <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      if (accept) begin
        op_reg      <= AluControl;
        a_reg       <= in_a;
        b_reg       <= in_b;
        acc_reg     <= '0;
        mcand_reg   <= {{WIDTH{1'b0}}, in_b};
        cnt_reg     <= '0;
        divzero_reg <= sc_divzero;
        illegal_reg <= sc_illegal;
      end else if (state_reg == RUN) begin
        if (op_reg == OP_MUL) begin
          acc_reg   <= mul_acc_step;
          a_reg     <= {1'b0, a_reg[WIDTH-1:1]};
          mcand_reg <= {mcand_reg[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_reg <= {{WIDTH{1'b0}}, div_rem_step};
          a_reg   <= div_quo_step;
        end
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (capture) begin
        out_reg   <= cap_result;
        zero_reg  <= (cap_result == '0);
        sign_reg  <= cap_result[WIDTH-1];
        carry_reg <= cap_carry;
        ovf_reg   <= cap_ovf;
      end
    end
  end

  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);
  assign out          = out_reg;
  assign zeroflag     = zero_reg;
  assign signflag     = sign_reg;
  assign carryflag    = carry_reg;
  assign overflowflag = ovf_reg;
  assign divzero      = divzero_reg;
  assign illegal_op   = illegal_reg;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed-vector bench for multicycle_alu at WIDTH=32 and WIDTH=8.
// Flag vectors are packed as {zero, sign, carry, overflow, divzero, illegal_op}.
module tb_multicycle_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, busy, done;
  logic [3:0]  op;
  logic [31:0] a, b, res;
  logic        zf, sf, cf, vf, dz, il;
  logic        start8, busy8, done8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, res8;
  logic        zf8, sf8, cf8, vf8, dz8, il8;
  logic [5:0]  fl32, fl8;

  assign fl32 = {zf, sf, cf, vf, dz, il};
  assign fl8  = {zf8, sf8, cf8, vf8, dz8, il8};

  int n_vec = 0;
  int n_err = 0;

  multicycle_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .AluControl(op), .in_a(a), .in_b(b),
    .busy(busy), .done(done), .out(res), .zeroflag(zf), .signflag(sf),
    .carryflag(cf), .overflowflag(vf), .divzero(dz), .illegal_op(il)
  );

  multicycle_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .AluControl(op8), .in_a(a8), .in_b(b8),
    .busy(busy8), .done(done8), .out(res8), .zeroflag(zf8), .signflag(sf8),
    .carryflag(cf8), .overflowflag(vf8), .divzero(dz8), .illegal_op(il8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble inputs after acceptance, optionally keep start high
  // (including the done cycle), and count cycles until done.
  task automatic run(input bit w8, input logic [3:0] o, input logic [31:0] x,
                     input logic [31:0] y, input bit poke, output int cycles);
    int guard = 0;
    while ((w8 ? busy8 : busy) && guard < 100) begin
      tick();
      guard++;
    end
    if (w8) begin start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0]; end
    else    begin start  = 1'b1; op  = o; a  = x;      b  = y;      end
    cycles = 0;
    do begin
      tick();
      cycles++;
      if (w8) begin start8 = poke; op8 = ~o; a8 = ~x[7:0]; b8 = ~y[7:0]; end
      else    begin start  = poke; op  = ~o; a  = ~x;      b  = ~y;      end
    end while (!(w8 ? done8 : done) && cycles < 200);
    if (cycles >= 200) check("done_timeout", 64'(cycles), 64'(0));
  endtask

  task automatic op32(input string tag, input logic [3:0] o, input logic [31:0] x,
                      input logic [31:0] y, input bit poke, input int cyc_e,
                      input logic [31:0] r_e, input logic [5:0] f_e);
    int c;
    run(1'b0, o, x, y, poke, c);
    $display("op32 %s: op=%0h a=0x%0h b=0x%0h -> out=0x%0h flags=%b cycles=%0d",
             tag, o, x, y, res, fl32, c);
    check({tag, "_cycles"}, 64'(c), 64'(cyc_e));
    check({tag, "_out"}, 64'(res), 64'(r_e));
    check({tag, "_flags"}, 64'(fl32), 64'(f_e));
    check({tag, "_busy"}, 64'(busy), 64'(1));
  endtask

  task automatic op8w(input string tag, input logic [3:0] o, input logic [7:0] x,
                      input logic [7:0] y, input int cyc_e,
                      input logic [7:0] r_e, input logic [5:0] f_e);
    int c;
    run(1'b1, o, {24'd0, x}, {24'd0, y}, 1'b0, c);
    $display("op8 %s: op=%0h a=0x%0h b=0x%0h -> out=0x%0h flags=%b cycles=%0d",
             tag, o, x, y, res8, fl8, c);
    check({tag, "_cycles"}, 64'(c), 64'(cyc_e));
    check({tag, "_out"}, 64'(res8), 64'(r_e));
    check({tag, "_flags"}, 64'(fl8), 64'(f_e));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen_done;
    rst_n = 1'b0;
    start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    tick();
    tick();
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_out", 64'(res), 64'(0));
    check("reset_flags", 64'(fl32), 64'(0));
    check("reset_busy8", 64'(busy8), 64'(0));
    rst_n = 1'b1;
    tick();

    op32("add_ovf",   4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1, 32'h8000_0000, 6'b010100);
    op32("add_carry", 4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, 32'h0000_0000, 6'b101000);
    op32("sll",       4'h4, 32'd32,        32'd2,         1'b0, 1, 32'd128,       6'b000000);
    op32("sll_out",   4'h4, 32'h8000_0000, 32'd1,         1'b0, 1, 32'h0000_0000, 6'b101000);
    op32("sra",       4'h6, 32'h8000_0000, 32'd4,         1'b0, 1, 32'hF800_0000, 6'b010000);
    op32("sra_zero",  4'h6, 32'h8000_0001, 32'd0,         1'b0, 1, 32'h8000_0001, 6'b010000);
    op32("srl_hib",   4'h5, 32'd3,         32'hFFFF_FFE1, 1'b0, 1, 32'd1,         6'b001000);
    op32("sub",       4'h1, 32'd5,         32'd3,         1'b0, 1, 32'd2,         6'b000000);
    op32("sub_ovf",   4'h1, 32'h8000_0000, 32'd1,         1'b0, 1, 32'h7FFF_FFFF, 6'b000100);
    op32("and",       4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1, 32'hF000_F000, 6'b010000);
    op32("or",        4'h3, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1, 32'hFFF0_FFF0, 6'b010000);
    op32("xor",       4'h7, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1, 32'h0FF0_0FF0, 6'b000000);
    op32("slt_true",  4'hB, 32'hFFFF_FFFF, 32'd1,         1'b0, 1, 32'd1,         6'b000000);
    op32("slt_false", 4'hB, 32'd1,         32'hFFFF_FFFF, 1'b0, 1, 32'd0,         6'b100000);

    op32("mul_hi",    4'h8, 32'h0001_0000, 32'h0001_0000, 1'b1, 33, 32'h0000_0000, 6'b101100);
    tick();
    check("start_in_done_ignored", 64'(busy), 64'(0));
    start = 1'b0;

    op32("mul",       4'h8, 32'd1234,      32'd5678,      1'b0, 33, 32'd7006652,  6'b000000);
    op32("divu",      4'h9, 32'd100,       32'd7,         1'b0, 33, 32'd14,       6'b000000);
    op32("remu",      4'hA, 32'd100,       32'd7,         1'b0, 33, 32'd2,        6'b000000);
    op32("divu_max",  4'h9, 32'hFFFF_FFFF, 32'd1,         1'b0, 33, 32'hFFFF_FFFF, 6'b010000);
    op32("remu_max",  4'hA, 32'hFFFF_FFFF, 32'h10,        1'b0, 33, 32'hF,        6'b000000);
    op32("divu_zero", 4'h9, 32'd5,         32'd0,         1'b0, 1, 32'hFFFF_FFFF, 6'b010010);
    op32("remu_zero", 4'hA, 32'd9,         32'd0,         1'b0, 1, 32'd9,         6'b000010);
    op32("dz_clear",  4'h0, 32'd2,         32'd3,         1'b0, 1, 32'd5,         6'b000000);

    tick(); tick(); tick();
    check("hold_out", 64'(res), 64'(5));
    check("hold_done", 64'(done), 64'(0));
    check("hold_busy", 64'(busy), 64'(0));

    // Abort a MUL with reset; a start held at the reset edge must be ignored.
    start = 1'b1; op = 4'h8; a = 32'd3; b = 32'd5;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("pre_reset_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    start = 1'b1; op = 4'h0; a = 32'd1; b = 32'd1;
    tick();
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_out", 64'(res), 64'(0));
    check("abort_flags", 64'(fl32), 64'(0));
    rst_n = 1'b1;
    start = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen_done = 1'b1;
    end
    check("abort_no_done", 64'(seen_done), 64'(0));
    op32("sub_after_rst", 4'h1, 32'd3, 32'd5, 1'b0, 1, 32'hFFFF_FFFE, 6'b011000);
    op32("illegal",       4'hC, 32'd1, 32'd2, 1'b0, 1, 32'd0,         6'b100001);

    op8w("mul8",     4'h8, 8'd15,  8'd17, 9, 8'hFF, 6'b010000);
    op8w("mul8_ovf", 4'h8, 8'd16,  8'd16, 9, 8'h00, 6'b101100);
    op8w("divu8",    4'h9, 8'd200, 8'd3,  9, 8'd66, 6'b000000);
    op8w("ill8",     4'hF, 8'd1,   8'd1,  1, 8'h00, 6'b100001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
